// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   localparam int          BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_bad_digit(input logic [BCD_W-1:0] d);
      return (d > BCD_MAX);
   endfunction

   // Out-of-range digits deliberately wrap mod 16 so that processing stays defined under err.
   function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] d);
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One decimal digit position: binary add of two digits plus carry, then +6 correction when the sum exceeds nine.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] a_d,
   input  logic [BCD_W-1:0] b_d,
   input  logic             cin,
   output logic [BCD_W-1:0] s_d,
   output logic             cout
);

   logic [BCD_W:0] raw;

   always_comb begin
      raw  = {1'b0, a_d} + {1'b0, b_d} + {{BCD_W{1'b0}}, cin};
      s_d  = raw[BCD_W-1:0];
      cout = 1'b0;
      if (raw > {1'b0, BCD_MAX}) begin
         s_d  = raw[BCD_W-1:0] + 4'd6;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor processing one digit per clock, LSD first, with start/done handshake.
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [BCD_W*DIGITS-1:0] a,
   input  logic [BCD_W*DIGITS-1:0] b,
   input  logic                  ci,
   output logic                  busy,
   output logic                  done,
   output logic [BCD_W*DIGITS-1:0] s,
   output logic                  co,
   output logic                  err
);

   localparam int W  = BCD_W * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   state_t          state;
   logic [IW-1:0]   idx;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            mode_q;
   logic            carry;

   logic [BCD_W-1:0] a_dig;
   logic [BCD_W-1:0] b_raw;
   logic [BCD_W-1:0] b_dig;
   logic [BCD_W-1:0] step_s;
   logic             step_c;
   logic             in_bad;

   // Subtraction reuses the adder: A - B - borrow == A + nines(B) + ~borrow.
   always_comb begin
      a_dig = a_q[idx*BCD_W +: BCD_W];
      b_raw = b_q[idx*BCD_W +: BCD_W];
      b_dig = mode_q ? nines_comp(b_raw) : b_raw;
   end

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         in_bad = in_bad | is_bad_digit(a[i*BCD_W +: BCD_W])
                         | is_bad_digit(b[i*BCD_W +: BCD_W]);
      end
   end

   bcd_digit_step u_step (
      .a_d  (a_dig),
      .b_d  (b_dig),
      .cin  (carry),
      .s_d  (step_s),
      .cout (step_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= 1'b0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         s      <= '0;
         co     <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  mode_q <= mode;
                  carry  <= mode ? ~ci : ci;
                  s      <= '0;
                  err    <= in_bad;
                  idx    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               s[idx*BCD_W +: BCD_W] <= step_s;
               carry <= step_c;
               if (idx == LAST_IDX) begin
                  co    <= step_c;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
